dmem_sized: RTL
===============

Name: dmem_sized

Overview:
- Parametrised successor to the single-port word data memory: byte/half/word loads and stores, sign/zero extension, byte-lane write enables, and configurable read latency.
- Sits between the processor MEM stage and the storage array.
- Uses a valid/ready request channel and a valid-only response channel, with one outstanding request.
- Flags misaligned and out-of-range accesses instead of silently truncating them.

Parameters:
- DEPTH, 64, number of 32-bit words; power of two, minimum 4.
- RD_LAT, 1, cycles from request accept to rsp_valid for every request (loads, stores, errors); range 1..4.

Ports:
- clk  in  1  system clock, shared with the processor.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle pulse: response available.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  with rsp_valid: request was misaligned, out of range, or illegal size.

Behaviour:
- Reset (async assert, sync deassert): state = IDLE; req_ready = 1; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; latency counter = 0.
- Memory contents are not reset and are undefined until written.
- Accept: occurs on a clk edge with req_valid & req_ready. All request fields are captured at that edge.
- FSM states: IDLE and WAIT.
  - IDLE: req_ready = 1. On accept, go to WAIT and load cnt = RD_LAT - 1.
  - WAIT: req_ready = 0. Decrement cnt each cycle.
  - When cnt == 0 in WAIT, assert rsp_valid for one cycle and return to IDLE.
  - For RD_LAT = 1, rsp_valid occurs in the cycle after accept.
  - No back-to-back accepts: maximum throughput is one request per RD_LAT + 1 cycles.
- Error check at accept, in priority order:
  1. Illegal size: req_size == 11.
  2. Misaligned: half with addr[0] = 1, or word with addr[1:0] != 0.
  3. Out of range: addr[31:2] >= DEPTH.
- An erroring request performs no write, and its response carries rsp_err = 1 and rsp_rdata = 0.
- Store: written at the accept edge through byte enables:
  - byte writes lane addr[1:0] with wdata[7:0];
  - half writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0];
  - word writes all lanes.
  - Other lanes are untouched. The response has rsp_err = 0 and rsp_rdata = 0.
- Load: word memory[addr[31:2]] is read at accept, then lane-selected and extended.
  - Byte: select lane addr[1:0]; extend bit 7 (sign) or 0 (unsigned).
  - Half: select lanes by addr[1]; extend bit 15 or 0.
  - Word: pass through; req_unsigned is ignored.
  - The result is held in the latency pipeline until rsp_valid.
- Ordering: a load after a store to the same word returns the post-store data, because the store completes before the next accept.
- rsp_rdata and rsp_err hold their last values between responses. Only rsp_valid qualifies them.
- Reset mid-operation: any pending response is discarded, and a write already committed at accept remains in memory.

Optional Feature:
- Macro: DMEM_SIZED_STATS_EN.
- With the macro defined, three extra output ports are added:
  - ld_cnt  out  16  accepted error-free loads.
  - st_cnt  out  16  accepted error-free stores.
  - err_cnt  out  16  accepted requests that errored.
- All three increment at accept, saturate at 16'hFFFF, and reset to 0.
- Without the macro, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- Package dmem_pkg holds:
  - typedef enum logic [1:0] size_t {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10};
  - typedef enum logic {ST_IDLE, ST_WAIT} dmem_state_t;
  - localparams for the lane count (4) and the stats width (16).
- One sub-module: dmem_load_align, purely combinational. Inputs: word, addr[1:0], size, unsigned. Output: extended data.
- The array, byte-enable generation, FSM and latency pipe stay in dmem_sized.

Test Plan:
- Store word 0xDEADBEEF to addr 0x10, then load word from 0x10, RD_LAT = 1 -> rsp_valid exactly 1 cycle after the load accept; rdata = 0xDEADBEEF; err = 0.
- Store byte 0x7F to addr 0x13, then signed-byte load from 0x13 and from 0x12 -> 0x0000007F and 0xFFFFFFAD; word at 0x10 now reads 0x7FADBEEF.
- Signed half load from 0x12 -> 0x00007FAD. Store half 0x8001 to 0x10, then signed and unsigned half loads from 0x10 -> 0xFFFF8001 and 0x00008001.
- Misaligned word load from 0x11, store half to 0x13, and word access at byte address 4*DEPTH -> err = 1 and rdata = 0 for each; memory unchanged, confirmed by a readback.
- RD_LAT = 3 with req_valid held high continuously -> req_ready low for 3 cycles after each accept; accepts spaced 4 cycles apart; one rsp_valid per request.
- Drop rst_n during ST_WAIT -> rsp_valid never asserts for that request; req_ready = 1 immediately; with stats enabled, all counters read 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, sizes and lane-mask helper for the sized data memory
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_t;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } dmem_state_t;

    localparam int LANES   = 4;
    localparam int STATS_W = 16;

    // Byte-lane write enables for a naturally aligned access; illegal size enables nothing.
    function automatic logic [LANES-1:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [LANES-1:0] m;
        case (size)
            SZ_B:    m = 4'b0001 << off;
            SZ_H:    m = off[1] ? 4'b1100 : 4'b0011;
            SZ_W:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - lane select and sign/zero extension of a loaded word
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        byte_ext;
    logic        half_ext;

    always_comb begin
        byte_sel = word_i[{addr_i, 3'b000} +: 8];
        half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
        byte_ext = ~unsigned_i & byte_sel[7];
        half_ext = ~unsigned_i & half_sel[15];
        case (size_i)
            SZ_B:    data_o = {{24{byte_ext}}, byte_sel};
            SZ_H:    data_o = {{16{half_ext}}, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/dmem_sized.sv
// rtl/dmem_sized.sv - byte/half/word data memory with fixed response latency; DMEM_SIZED_STATS_EN adds access counters
module dmem_sized
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_SIZED_STATS_EN
    ,
    output logic [STATS_W-1:0] ld_cnt,
    output logic [STATS_W-1:0] st_cnt,
    output logic [STATS_W-1:0] err_cnt
`endif
);

    localparam int  AW   = $clog2(DEPTH);
    localparam int  CW   = 2;
    localparam bit  LAT1 = (RD_LAT == 1);

    dmem_state_t     state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     pend_rdata_q;
    logic            pend_err_q;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic [31:0]     mem_q [DEPTH];

    logic            accept;
    logic            size_bad, misal, oor, req_err;
    logic [AW-1:0]   idx;
    logic [LANES-1:0] be;
    logic [31:0]     wlane;
    logic [31:0]     ld_data;
    logic [31:0]     now_rdata;

    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid & req_ready;
    assign rsp_valid = (state_q == ST_WAIT) && (cnt_q == '0);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    assign idx      = req_addr[AW+1:2];
    assign size_bad = (req_size == 2'b11);
    assign misal    = ((req_size == SZ_H) && req_addr[0]) ||
                      ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
    assign oor      = (req_addr[31:2] >= 30'(DEPTH));
    assign req_err  = size_bad | misal | oor;

    assign be = lane_mask(req_size, req_addr[1:0]);

    always_comb begin
        case (req_size)
            SZ_B:    wlane = {4{req_wdata[7:0]}};
            SZ_H:    wlane = {2{req_wdata[15:0]}};
            default: wlane = req_wdata;
        endcase
    end

    dmem_load_align u_align (
        .word_i     (mem_q[idx]),
        .addr_i     (req_addr[1:0]),
        .size_i     (req_size),
        .unsigned_i (req_unsigned),
        .data_o     (ld_data)
    );

    assign now_rdata = (req_err || req_we) ? 32'h0 : ld_data;

    // Storage is never reset; the write commits at the accept edge.
    always_ff @(posedge clk) begin
        if (accept && req_we && !req_err) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) begin
                    mem_q[idx][8*i +: 8] <= wlane[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_WAIT;
                    cnt_d   = CW'(RD_LAT - 1);
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Response registers change only on the edge that opens the response cycle,
    // so they hold the previous response until then.
    always_comb begin
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (LAT1 && accept) begin
            rsp_rdata_d = now_rdata;
            rsp_err_d   = req_err;
        end else if (!LAT1 && (state_q == ST_WAIT) && (cnt_q == CW'(1))) begin
            rsp_rdata_d = pend_rdata_q;
            rsp_err_d   = pend_err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            pend_rdata_q <= '0;
            pend_err_q   <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            if (accept) begin
                pend_rdata_q <= now_rdata;
                pend_err_q   <= req_err;
            end
        end
    end

`ifdef DMEM_SIZED_STATS_EN
    logic [STATS_W-1:0] ld_cnt_q, st_cnt_q, err_cnt_q;

    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt_q  <= '0;
            st_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else if (accept) begin
            if (req_err) begin
                err_cnt_q <= sat_inc(err_cnt_q);
            end else if (req_we) begin
                st_cnt_q <= sat_inc(st_cnt_q);
            end else begin
                ld_cnt_q <= sat_inc(ld_cnt_q);
            end
        end
    end

    assign ld_cnt  = ld_cnt_q;
    assign st_cnt  = st_cnt_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule
